// File: rtl/alu_param_pkg.sv
// Shared types for the parametrised ALU: operation codes, FSM states and op decode.
package alu_param_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_MUL  = 3'b100,
    OP_SUB  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_WAIT_LOW
  } state_t;

  // Reserved codes behave exactly like no_op: nothing is captured.
  function automatic logic op_valid(input operation_t o);
    return (o != OP_NOP) && (o != OP_RSV6) && (o != OP_RSV7);
  endfunction

endpackage

// File: rtl/alu_param_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock, DATA_W iterations after load.
module alu_param_mul #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  valid,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic                run;

  // mcand holds A << cnt and mplier[0] is B[cnt], so no variable shift is needed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run     <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (load) begin
      run     <= 1'b1;
      cnt     <= '0;
      mcand   <= {{DATA_W{1'b0}}, a};
      mplier  <= b;
      product <= '0;
    end else if (run) begin
      if (cnt == LAST) begin
        run <= 1'b0;
      end else begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end

  assign busy  = run;
  assign valid = run && (cnt == LAST);

endmodule

// File: rtl/alu_param.sv
// Parametrised ALU with start/done handshake; optional zero/carry flags under ALU_FLAGS_EN.
module alu_param
  import alu_param_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  operation_t            op,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  output logic                  done,
  output logic                  busy,
  output logic [2*DATA_W-1:0]   result
`ifdef ALU_FLAGS_EN
  ,
  output logic                  zero,
  output logic                  carry
`endif
);

  localparam int W2 = 2 * DATA_W;

  state_t              state, state_next;
  logic [DATA_W-1:0]   a_q, b_q;
  operation_t          op_q;
  logic [W2-1:0]       a_x, b_x, res_next;
  logic                mul_load, mul_busy, mul_valid;
  logic [W2-1:0]       mul_product;

  assign a_x      = {{DATA_W{1'b0}}, a_q};
  assign b_x      = {{DATA_W{1'b0}}, b_q};
  assign mul_load = (state == S_IDLE) && start && (op == OP_MUL);

  alu_param_mul #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (mul_load),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .valid   (mul_valid),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start && op_valid(op)) state_next = (op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC:     state_next = S_WAIT_LOW;
      S_MUL:      if (mul_valid) state_next = S_WAIT_LOW;
      S_WAIT_LOW: if (!start) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // The multiplier is running exactly while the FSM sits in MUL.
  always_comb begin
    busy = (state == S_EXEC) || mul_busy;
  end

  always_comb begin
    res_next = '0;
    case (op_q)
      OP_ADD:  res_next = a_x + b_x;
      OP_AND:  res_next = a_x & b_x;
      OP_XOR:  res_next = a_x ^ b_x;
      OP_SUB:  res_next = a_x - b_x;
      OP_MUL:  res_next = mul_product;
      default: res_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_NOP;
      done   <= 1'b0;
      result <= '0;
`ifdef ALU_FLAGS_EN
      zero   <= 1'b0;
      carry  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && state_next != S_IDLE) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
      end
      if (state != S_WAIT_LOW && state_next == S_WAIT_LOW) begin
        result <= res_next;
        done   <= 1'b1;
`ifdef ALU_FLAGS_EN
        zero   <= (res_next == '0);
        carry  <= (op_q == OP_ADD) ? res_next[DATA_W] :
                  (op_q == OP_SUB) ? (a_q < b_q) : 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_param.sv
// Self-checking bench for alu_param at DATA_W=8 and DATA_W=16; flag checks under ALU_FLAGS_EN.
`timescale 1ns/1ps
module tb_alu_param;
  import alu_param_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start8, start16;
  operation_t  op8, op16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        done8, busy8, done16, busy16;
  logic [15:0] res8;
  logic [31:0] res16;
`ifdef ALU_FLAGS_EN
  logic zero8, carry8, zero16, carry16;
`endif

  alu_param #(.DATA_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op(op8), .A(a8), .B(b8),
    .done(done8), .busy(busy8), .result(res8)
`ifdef ALU_FLAGS_EN
    , .zero(zero8), .carry(carry8)
`endif
  );

  alu_param #(.DATA_W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .op(op16), .A(a16), .B(b16),
    .done(done16), .busy(busy16), .result(res16)
`ifdef ALU_FLAGS_EN
    , .zero(zero16), .carry(carry16)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  longint unsigned last8 = 0;
  longint unsigned last16 = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic on unbounded integers, reduced to the 2*w-bit result.
  function automatic longint unsigned model(input operation_t o, input longint unsigned a,
                                            input longint unsigned b, input int w);
    longint unsigned mask = (64'd1 << (2 * w)) - 64'd1;
    case (o)
      OP_ADD:  return (a + b) & mask;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_MUL:  return (a * b) & mask;
      OP_SUB:  return (a - b) & mask;
      default: return 0;
    endcase
  endfunction

  function automatic longint unsigned model_carry(input operation_t o, input longint unsigned a,
                                                  input longint unsigned b, input int w);
    if (o == OP_ADD) return ((a + b) >= (64'd1 << w)) ? 1 : 0;
    if (o == OP_SUB) return (a < b) ? 1 : 0;
    return 0;
  endfunction

  function automatic int model_lat(input operation_t o, input int w);
    return (o == OP_MUL) ? w + 1 : 1;
  endfunction

  task automatic run8(input operation_t o, input logic [7:0] a, input logic [7:0] b,
                      input longint unsigned exp, input bit hold, input string tag);
    int lat = 0, busy_n = 0, extra = 0;
    bit got = 0;
    @(negedge clk);
    op8 = o; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    if (busy8) busy_n++;
    if (!hold) start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = operation_t'($urandom_range(0, 7));
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (done8) begin got = 1; lat = i; end
      else if (busy8) busy_n++;
    end
    chk($sformatf("%s done seen", tag), got, 1);
    chk($sformatf("%s latency", tag), lat, model_lat(o, 8));
    chk($sformatf("%s busy cycles", tag), busy_n, model_lat(o, 8));
    chk($sformatf("%s busy at done", tag), busy8, 0);
    chk($sformatf("%s result", tag), res8, exp);
`ifdef ALU_FLAGS_EN
    chk($sformatf("%s zero", tag), zero8, (exp == 0) ? 1 : 0);
    chk($sformatf("%s carry", tag), carry8, model_carry(o, a, b, 8));
`endif
    last8 = exp;
    @(posedge clk); #1;
    chk($sformatf("%s done single", tag), done8, 0);
    if (hold) begin
      repeat (18) begin
        @(posedge clk); #1;
        if (done8) extra++;
      end
      chk($sformatf("%s held start retrigger", tag), extra, 0);
    end
    start8 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run16(input operation_t o, input logic [15:0] a, input logic [15:0] b,
                       input longint unsigned exp, input string tag);
    int lat = 0;
    bit got = 0;
    @(negedge clk);
    op16 = o; a16 = a; b16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    for (int i = 1; i <= 60 && !got; i++) begin
      @(posedge clk); #1;
      if (done16) begin got = 1; lat = i; end
    end
    chk($sformatf("%s done seen", tag), got, 1);
    chk($sformatf("%s latency", tag), lat, model_lat(o, 16));
    chk($sformatf("%s result", tag), res16, exp);
`ifdef ALU_FLAGS_EN
    chk($sformatf("%s carry", tag), carry16, model_carry(o, a, b, 16));
`endif
    last16 = exp;
    @(posedge clk); #1;
    chk($sformatf("%s done single", tag), done16, 0);
  endtask

  task automatic nop8(input operation_t o);
    int activity = 0;
    @(negedge clk);
    op8 = o; a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (done8 || busy8) activity++;
    end
    start8 = 1'b0;
    chk($sformatf("nop op=%0d no done/busy", o), activity, 0);
    chk($sformatf("nop op=%0d result held", o), res8, last8);
  endtask

  typedef struct {
    operation_t  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    bit          hold;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int activity;
    operation_t ro;
    logic [7:0] ra, rb;
    logic [15:0] r16a, r16b;

    vecs[0] = '{OP_ADD, 8'hFF, 8'hFF, 16'h01FE, 1'b1};
    vecs[1] = '{OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
    vecs[2] = '{OP_MUL, 8'h00, 8'hFF, 16'h0000, 1'b0};
    vecs[3] = '{OP_SUB, 8'h03, 8'h05, 16'hFFFE, 1'b0};
    vecs[4] = '{OP_AND, 8'hF0, 8'h3C, 16'h0030, 1'b0};
    vecs[5] = '{OP_XOR, 8'hF0, 8'h3C, 16'h00CC, 1'b1};
    vecs[6] = '{OP_MUL, 8'h0D, 8'h0B, 16'h008F, 1'b1};
    vecs[7] = '{OP_SUB, 8'h05, 8'h03, 16'h0002, 1'b0};

    reset_n = 1'b0;
    start8 = 1'b0; op8 = OP_NOP; a8 = '0; b8 = '0;
    start16 = 1'b0; op16 = OP_NOP; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset done8", done8, 0);
    chk("reset busy8", busy8, 0);
    chk("reset result8", res8, 0);
    chk("reset done16", done16, 0);
    chk("reset result16", res16, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i])
      run8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, $sformatf("vec%0d", i));

    nop8(OP_NOP);
    nop8(OP_RSV6);
    nop8(OP_RSV7);

    // Abort a multiply with a one-edge reset on its 4th cycle.
    @(negedge clk);
    op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    last8 = 0; last16 = 0;
    chk("abort busy", busy8, 0);
    chk("abort result", res8, 0);
    activity = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8 || busy8) activity++;
    end
    chk("abort no done", activity, 0);
    chk("abort result stays 0", res8, 0);
`ifdef ALU_FLAGS_EN
    chk("abort zero flag", zero8, 0);
    chk("abort carry flag", carry8, 0);
`endif
    run8(OP_ADD, 8'h01, 8'h01, 16'h0002, 1'b0, "post-abort add");

    for (int k = 0; k < 30; k++) begin
      ro = operation_t'($urandom_range(1, 5));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (k % 7 == 0) rb = ra;
      run8(ro, ra, rb, model(ro, ra, rb, 8), bit'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end

    run16(OP_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16 mul max");
    for (int k = 0; k < 6; k++) begin
      ro = operation_t'($urandom_range(1, 5));
      r16a = 16'($urandom);
      r16b = 16'($urandom);
      run16(ro, r16a, r16b, model(ro, r16a, r16b, 16), $sformatf("w16 rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
